rep_add_mult: RTL

Parametrised sequential multiplier that forms `product = a * b` by repeated addition under control of an internal FSM. It is the WIDTH-generic successor to the fixed 16-bit repeated-addition multiplier. It adds a start/busy/done handshake, a zero-operand early exit, synchronous reset and an optional operand-swap mode. It sits as a leaf arithmetic unit behind any master that can hold off issuing `start` while `busy` is high.

---
 rtl/rep_add_mult_pkg.sv | 19 +
 rtl/rep_add_mult_dp.sv | 91 +++++++++
 rtl/rep_add_mult.sv | 99 +++++++++
 3 files changed

// File: rtl/rep_add_mult_pkg.sv
// -----------------------------------------------------------------------------
// rep_add_mult_pkg
//   Shared definitions for the repeated-addition multiplier.
//   Contents:
//     DEFAULT_WIDTH : default operand width (bits)
//     state_t       : controller state encoding (IDLE, RUN, DONE)
//   Optional feature macro used by the design: REP_ADD_MULT_SWAP_EN
// -----------------------------------------------------------------------------
package rep_add_mult_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rep_add_mult_dp.sv
// -----------------------------------------------------------------------------
// rep_add_mult_dp
//   Datapath of the repeated-addition multiplier: multiplicand register,
//   iteration counter, 2*WIDTH accumulator and the counter-is-zero flag.
//   Configuration macro: REP_ADD_MULT_SWAP_EN
//     defined   : on load, the smaller operand becomes the iteration count and
//                 the larger one the addend (tie keeps a as the addend)
//     undefined : count = b, addend = a
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   synchronous active-low reset
//     load     in   capture operands into addend register and counter
//     clear    in   zero the accumulator
//     add      in   accumulate one addend and decrement the counter
//     a, b     in   WIDTH-bit unsigned operands
//     eq_z     out  counter is zero
//     product  out  2*WIDTH-bit accumulator
// -----------------------------------------------------------------------------
module rep_add_mult_dp
   import rep_add_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 clear,
   input  logic                 add,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 eq_z,
   output logic [2*WIDTH-1:0]   product
);

   logic [WIDTH-1:0]   reg_a_reg;
   logic [WIDTH-1:0]   cnt_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0]   load_a;
   logic [WIDTH-1:0]   load_cnt;
   logic               cnt_zero;
   logic               add_ok;

   // Operand routing into the addend register and counter.
   always_comb begin
      load_a   = a;
      load_cnt = b;
`ifdef REP_ADD_MULT_SWAP_EN
      // Count down the smaller operand so latency is bounded by min(a,b).
      // ">=" keeps a as the addend when the operands are equal.
      if (a >= b) begin
         load_a   = a;
         load_cnt = b;
      end else begin
         load_a   = b;
         load_cnt = a;
      end
`endif
   end

   assign cnt_zero = (cnt_reg == '0);

   // Never step past zero, even if the controller were to request it.
   assign add_ok = add && !cnt_zero;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_a_reg <= '0;
         cnt_reg   <= '0;
         acc_reg   <= '0;
      end else begin
         if (load) begin
            reg_a_reg <= load_a;
            cnt_reg   <= load_cnt;
         end else if (add_ok) begin
            cnt_reg   <= cnt_reg - 1'b1;
         end

         // Addend is zero-extended; the 2*WIDTH accumulator holds
         // (2^WIDTH-1)^2 so it cannot wrap.
         if (clear) begin
            acc_reg <= '0;
         end else if (add_ok) begin
            acc_reg <= acc_reg + {{WIDTH{1'b0}}, reg_a_reg};
         end
      end
   end

   assign eq_z    = cnt_zero;
   assign product = acc_reg;

endmodule

// File: rtl/rep_add_mult.sv
// -----------------------------------------------------------------------------
// rep_add_mult
//   Sequential unsigned multiplier: product = a * b, formed by repeated
//   addition under a three-state controller (IDLE -> RUN -> DONE -> IDLE).
//   Latency from the start-sampling edge to done is N+1 clocks, where N is the
//   effective iteration count (b, or min(a,b) with swap mode).
//   Configuration macro: REP_ADD_MULT_SWAP_EN (operand swap, see datapath).
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   synchronous active-low reset (priority over start)
//     start    in   request, accepted only in IDLE
//     a, b     in   WIDTH-bit unsigned operands, sampled with start
//     busy     out  high while the multiply is running (registered)
//     done     out  one-cycle pulse, product valid while high (registered)
//     product  out  2*WIDTH-bit result, held until the next accepted start
// -----------------------------------------------------------------------------
module rep_add_mult
   import rep_add_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   state_t state_reg;
   logic   busy_reg;
   logic   done_reg;
   logic   accept;
   logic   do_add;
   logic   eq_z;

   // A request is taken only from IDLE; start in RUN/DONE is simply dropped.
   assign accept = (state_reg == ST_IDLE) && start;
   assign do_add = (state_reg == ST_RUN) && !eq_z;

   // Controller. busy/done are registered alongside the state so they are
   // pure flop outputs with no path from the inputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg <= ST_RUN;
                  busy_reg  <= 1'b1;
               end
            end
            ST_RUN: begin
               // The zero check happens before any addition, so b=0 still
               // spends exactly one cycle in RUN.
               if (eq_z) begin
                  state_reg <= ST_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   rep_add_mult_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .clear   (accept),
      .add     (do_add),
      .a       (a),
      .b       (b),
      .eq_z    (eq_z),
      .product (product)
   );

   assign busy = busy_reg;
   assign done = done_reg;

endmodule
